seq_detector_1101: RTL and testbench

Serial bit-pattern detector. It samples one input bit per clock and raises a one-cycle flag each time the bit sequence 1-1-0-1 (first-received bit first) has just completed. It is a small Moore FSM for control/protocol front ends that need to spot a fixed preamble or marker in a serial stream.

---
 rtl/seq_detector_pkg.sv | 11 +
 rtl/seq_detector_1101.sv | 34 +++
 tb/tb_seq_detector_1101.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared state encoding and pattern constant for the 1101 detector
package seq_detector_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S11  = 3'd2,
        S110 = 3'd3,
        DET  = 3'd4
    } state_t;
    localparam logic [3:0] PATTERN = 4'b1101;
endpackage

// File: rtl/seq_detector_1101.sv
// seq_detector_1101: Moore FSM flagging each completed 1-1-0-1 serial sequence
// clk : rising-edge clock
// rst : asynchronous active-low reset, forces IDLE and out=0
// in  : serial data bit, sampled each rising edge
// out : one-cycle detection flag, decoded from state only
module seq_detector_1101
    import seq_detector_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    state_t state, state_nxt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = in ? S1  : IDLE;
            S1:      state_nxt = in ? S11 : IDLE;
            S11:     state_nxt = in ? S11 : S110;
            S110:    state_nxt = in ? DET : IDLE;
            // with overlap the trailing 1 plus the new 1 already form "11"
            DET:     state_nxt = in ? ((OVERLAP != 0) ? S11 : S1) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign out = (state == DET);
endmodule

// File: tb/tb_seq_detector_1101.sv
// tb_seq_detector_1101: scoreboard bench running overlap and non-overlap detectors side by side
module tb_seq_detector_1101;
    import seq_detector_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d   = 1'b0;
    logic out_ov, out_no;
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [3:0] hist = 4'b0;
    int cnt_ov = 0;
    int cnt_no = 0;
    int pulses_ov = 0;
    int pulses_no = 0;
    seq_detector_1101 #(.OVERLAP(1)) u_ov (.clk(clk), .rst(rst), .in(d), .out(out_ov));
    seq_detector_1101 #(.OVERLAP(0)) u_no (.clk(clk), .rst(rst), .in(d), .out(out_no));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        hist   = 4'b0;
        cnt_ov = 0;
        cnt_no = 0;
    endtask
    task automatic step(input logic b, input string tag);
        logic e_ov, e_no;
        logic [1:0] e;
        d    = b;
        hist = {hist[2:0], b};
        cnt_ov++;
        cnt_no++;
        e_ov = (cnt_ov >= 4) && (hist == PATTERN);
        e_no = (cnt_no >= 4) && (hist == PATTERN);
        if (e_no) cnt_no = 0;
        exp_q.push_back({e_ov, e_no});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ov"}, {7'd0, out_ov}, {7'd0, e[1]});
            chk({tag, "_no"}, {7'd0, out_no}, {7'd0, e[0]});
        end
        pulses_ov += int'(out_ov);
        pulses_no += int'(out_no);
    endtask
    task automatic run(input logic [15:0] bits, input int n, input string tag,
                       input int want_ov, input int want_no);
        pulses_ov = 0;
        pulses_no = 0;
        for (int i = n - 1; i >= 0; i--) step(bits[i], tag);
        chk({tag, "_npulse_ov"}, pulses_ov[7:0], want_ov[7:0]);
        chk({tag, "_npulse_no"}, pulses_no[7:0], want_no[7:0]);
    endtask
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_out_ov"}, {7'd0, out_ov}, 8'd0);
        chk({tag, "_out_no"}, {7'd0, out_no}, 8'd0);
        chk({tag, "_state"}, {5'd0, u_ov.state}, {5'd0, IDLE});
        #1;
        rst = 1'b1;
        model_reset();
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d = ~d;
            chk("rst_out_ov", {7'd0, out_ov}, 8'd0);
            chk("rst_out_no", {7'd0, out_no}, 8'd0);
            chk("rst_state_ov", {5'd0, u_ov.state}, {5'd0, IDLE});
            chk("rst_state_no", {5'd0, u_no.state}, {5'd0, IDLE});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run(16'b0000_0011_0101_1010, 12, "basic", 2, 2);
        async_reset("r1");
        run(16'b0000_0000_0110_1101, 7, "overlap", 2, 1);
        async_reset("r2");
        run(16'b0000_0000_0111_1101, 7, "ones", 1, 1);
        async_reset("r3");
        run(16'b0000_1011_1001_1001, 12, "near", 0, 0);
        async_reset("r4");
        run(16'b0000_0000_0000_0110, 3, "mid_pre", 0, 0);
        async_reset("mid");
        run(16'b0000_0000_0000_0001, 1, "mid_post", 0, 0);
        run(16'b0000_0000_0000_1101, 4, "mid_again", 1, 1);
        chk("det_hold_ov", {7'd0, out_ov}, 8'd1);
        async_reset("rst_in_det");
        chk("queue_empty", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
